// File: rtl/packetizer.sv
// Transmit framer: buffers one byte-stream packet, then emits training, BPSK header,
// BPSK/QPSK payload and an idle gap, one symbol per clk_enable strobe.
module packetizer #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 300,
  parameter int unsigned TRN_LEN           = 32,
  parameter int unsigned GAP_LEN           = 16,
  parameter logic [7:0]  SIGNATURE         = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_enable,
  input  logic       mode_bpsk,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  output logic       out_valid,
  output logic       out_BPSK,
  output logic [1:0] out_QPSK,
  output logic       is_bpsk,
  output logic       out_sof,
  output logic       drop,
  output logic       tx_busy
);

  localparam int unsigned NbW   = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int unsigned AddrW = $clog2(MAX_PAYLOAD_BYTES);

  typedef enum logic [2:0] {StIdle, StLoad, StDiscard, StTrn, StHdr, StPld, StGap} state_e;

  state_e           r_state, w_state_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic [NbW-1:0]   r_nbytes, w_nbytes_nxt;
  logic [NbW-1:0]   r_byte_idx, w_byte_idx_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_drop, w_drop_nxt;
  logic [7:0]       r_cur_byte, w_cur_byte_nxt;
  logic [7:0]       r_rd_data;
  logic [7:0]       r_mem [MAX_PAYLOAD_BYTES];

  logic             w_beat;
  logic             w_wr_en;
  logic [AddrW-1:0] w_wr_addr;
  logic [NbW-1:0]   w_rd_next;
  logic [AddrW-1:0] w_rd_addr;
  logic [15:0]      w_nb16;
  logic [15:0]      w_pld_last;
  logic [63:0]      w_hdr;

  assign w_beat     = s_tvalid & s_tready;
  assign w_nb16     = 16'(r_nbytes);
  assign w_pld_last = (r_mode ? (w_nb16 << 3) : (w_nb16 << 2)) - 16'd1;
  assign w_hdr      = {(r_mode ? 8'h20 : 8'h00), (w_nb16 << 3), SIGNATURE, 32'h0};

  // Read port always looks one byte ahead of the byte being shifted out; outside
  // PLD it parks on byte 0 so the first payload byte is ready at HDR end.
  assign w_rd_next = r_byte_idx + NbW'(1);
  assign w_rd_addr = (r_state == StPld && w_rd_next < NbW'(MAX_PAYLOAD_BYTES)) ?
                     w_rd_next[AddrW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= s_tdata;
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_nbytes   <= '0;
      r_byte_idx <= '0;
      r_mode     <= 1'b1;
      r_drop     <= 1'b0;
      r_cur_byte <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_nbytes   <= w_nbytes_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_mode     <= w_mode_nxt;
      r_drop     <= w_drop_nxt;
      r_cur_byte <= w_cur_byte_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_nbytes_nxt   = r_nbytes;
    w_byte_idx_nxt = r_byte_idx;
    w_mode_nxt     = r_mode;
    w_drop_nxt     = 1'b0;
    w_cur_byte_nxt = r_cur_byte;
    w_wr_en        = 1'b0;
    w_wr_addr      = r_nbytes[AddrW-1:0];
    unique case (r_state)
      StIdle: begin
        if (w_beat) begin
          w_wr_en      = 1'b1;
          w_wr_addr    = '0;
          w_nbytes_nxt = NbW'(1);
          w_mode_nxt   = mode_bpsk;
          w_cnt_nxt    = '0;
          w_state_nxt  = s_tlast ? StTrn : StLoad;
        end
      end
      StLoad: begin
        if (w_beat) begin
          if (r_nbytes == NbW'(MAX_PAYLOAD_BYTES)) begin
            // No room for this beat: the packet is lost whether or not it is the last.
            w_drop_nxt  = 1'b1;
            w_state_nxt = s_tlast ? StIdle : StDiscard;
          end else begin
            w_wr_en      = 1'b1;
            w_nbytes_nxt = r_nbytes + NbW'(1);
            if (s_tlast) begin
              w_cnt_nxt   = '0;
              w_state_nxt = StTrn;
            end
          end
        end
      end
      StDiscard: begin
        if (w_beat && s_tlast) w_state_nxt = StIdle;
      end
      StTrn: begin
        if (clk_enable) begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_cnt == 16'(TRN_LEN - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = StHdr;
          end
        end
      end
      StHdr: begin
        if (clk_enable) begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_cnt == 16'd63) begin
            w_cnt_nxt      = '0;
            w_cur_byte_nxt = r_rd_data;
            w_byte_idx_nxt = '0;
            w_state_nxt    = StPld;
          end
        end
      end
      StPld: begin
        if (clk_enable) begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_mode ? (r_cnt[2:0] == 3'd7) : (r_cnt[1:0] == 2'd3)) begin
            w_cur_byte_nxt = r_rd_data;
            w_byte_idx_nxt = w_rd_next;
          end
          if (r_cnt == w_pld_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = StGap;
          end
        end
      end
      StGap: begin
        if (clk_enable) begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_cnt == 16'(GAP_LEN - 1)) begin
            w_cnt_nxt    = '0;
            w_nbytes_nxt = '0;
            w_state_nxt  = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_BPSK  = 1'b0;
    out_QPSK  = 2'b00;
    is_bpsk   = 1'b1;
    out_sof   = 1'b0;
    unique case (r_state)
      StTrn: begin
        out_valid = 1'b1;
        out_BPSK  = ~r_cnt[0];
        out_QPSK  = {2{~r_cnt[0]}};
        out_sof   = (r_cnt == 16'd0);
      end
      StHdr: begin
        out_valid = 1'b1;
        out_BPSK  = w_hdr[6'd63 - r_cnt[5:0]];
        out_QPSK  = {2{w_hdr[6'd63 - r_cnt[5:0]]}};
      end
      StPld: begin
        out_valid = 1'b1;
        is_bpsk   = r_mode;
        if (r_mode) begin
          out_BPSK = r_cur_byte[3'd7 - r_cnt[2:0]];
          out_QPSK = {2{r_cur_byte[3'd7 - r_cnt[2:0]]}};
        end else begin
          out_BPSK = r_cur_byte[3'd7 - {r_cnt[1:0], 1'b0}];
          out_QPSK = {r_cur_byte[3'd7 - {r_cnt[1:0], 1'b0}],
                      r_cur_byte[3'd6 - {r_cnt[1:0], 1'b0}]};
        end
      end
      default: ;
    endcase
  end

  assign s_tready = (r_state == StIdle) || (r_state == StLoad) || (r_state == StDiscard);
  assign tx_busy  = (r_state != StIdle) && (r_state != StLoad);
  assign drop     = r_drop;

endmodule
